// File: rtl/tl_pkg.sv
// Shared light encodings, fault codes and monitor states for the traffic-light safety monitor.
package tl_pkg;

  localparam logic [1:0] LIGHT_GREEN   = 2'b10;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    FAULT_NONE         = 3'd0,
    FAULT_ILLEGAL      = 3'd1,
    FAULT_CONFLICT     = 3'd2,
    FAULT_BAD_SEQ      = 3'd3,
    FAULT_SHORT_YELLOW = 3'd4,
    FAULT_STARVATION   = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    MON_INIT  = 2'd0,
    MON_OK    = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_e;

endpackage

// File: rtl/tl_approach_checker.sv
// Per-approach checker: remembers the previous light code and how long yellow has been shown,
// and flags illegal codes, illegal transitions and yellow phases that end too early.
module tl_approach_checker
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW_CYC = 8,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] light,
  output logic       illegal,
  output logic       bad_seq,
  output logic       short_yellow
);

  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             legal_step;

  always_comb begin
    prev_d  = light;
    dwell_d = '0;
    if (light == LIGHT_YELLOW) begin
      if (prev_q != LIGHT_YELLOW) begin
        dwell_d = CNT_W'(1);
      end else if (dwell_q != {CNT_W{1'b1}}) begin
        dwell_d = dwell_q + CNT_W'(1);
      end else begin
        dwell_d = dwell_q;
      end
    end
  end

  // Holding a code is always fine; only G->Y, Y->R and R->G may change it.
  always_comb begin
    legal_step = (light == prev_q) ||
                 ((prev_q == LIGHT_GREEN)  && (light == LIGHT_YELLOW)) ||
                 ((prev_q == LIGHT_YELLOW) && (light == LIGHT_RED))    ||
                 ((prev_q == LIGHT_RED)    && (light == LIGHT_GREEN));
    illegal      = (light == LIGHT_ILLEGAL);
    bad_seq      = !legal_step;
    short_yellow = (prev_q == LIGHT_YELLOW) && (light == LIGHT_RED) &&
                   (dwell_q < CNT_W'(MIN_YELLOW_CYC));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= LIGHT_RED;
      dwell_q <= '0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
    end
  end

endmodule

// File: rtl/tl_safety_monitor.sv
// Passive traffic-light safety monitor: latches the first fault and requests flashing red.
// Optional starvation check on the crossing sensor is built when TLMON_STARVE_EN is defined.
module tl_safety_monitor
  import tl_pkg::*;
#(
  parameter int MIN_YELLOW_CYC = 8,
  parameter int MAX_WAIT_CYC   = 64,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Light_Highway,
  input  logic [1:0] Light_Crossing,
  input  logic       sensor,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       force_flash,
  output logic [7:0] fault_cnt
);

  mon_state_e  state_q, state_d;
  fault_code_e code_q, code_d, fire_code;
  logic [7:0]  cnt_q, cnt_d;
  logic        hw_illegal, hw_bad_seq, hw_short;
  logic        cr_illegal, cr_bad_seq, cr_short;
  logic        conflict, starve_fire, seq_en, any_fire;

  tl_approach_checker #(.MIN_YELLOW_CYC(MIN_YELLOW_CYC), .CNT_W(CNT_W)) u_hw_chk (
    .clk(clk), .rst(rst), .light(Light_Highway),
    .illegal(hw_illegal), .bad_seq(hw_bad_seq), .short_yellow(hw_short)
  );

  tl_approach_checker #(.MIN_YELLOW_CYC(MIN_YELLOW_CYC), .CNT_W(CNT_W)) u_cr_chk (
    .clk(clk), .rst(rst), .light(Light_Crossing),
    .illegal(cr_illegal), .bad_seq(cr_bad_seq), .short_yellow(cr_short)
  );

`ifdef TLMON_STARVE_EN
  logic [CNT_W-1:0] wait_q, wait_d;

  // The counter parks at the limit so the starvation check fires only once per wait.
  always_comb begin
    wait_d      = '0;
    starve_fire = 1'b0;
    if (sensor && (Light_Crossing != LIGHT_GREEN)) begin
      wait_d      = (wait_q == CNT_W'(MAX_WAIT_CYC)) ? wait_q : wait_q + CNT_W'(1);
      starve_fire = (wait_q == CNT_W'(MAX_WAIT_CYC - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end
`else
  logic unused_sensor;
  assign unused_sensor = sensor;
  assign starve_fire   = 1'b0;
`endif

  // Sequence checks need a valid previous code, so they stay off while re-initialising.
  always_comb begin
    seq_en    = (state_q != MON_INIT);
    conflict  = (Light_Highway != LIGHT_RED) && (Light_Crossing != LIGHT_RED);
    fire_code = FAULT_NONE;
    if (hw_illegal || cr_illegal)                 fire_code = FAULT_ILLEGAL;
    else if (conflict)                            fire_code = FAULT_CONFLICT;
    else if (seq_en && (hw_bad_seq || cr_bad_seq)) fire_code = FAULT_BAD_SEQ;
    else if (seq_en && (hw_short || cr_short))     fire_code = FAULT_SHORT_YELLOW;
    else if (seq_en && starve_fire)                fire_code = FAULT_STARVATION;
    any_fire = (fire_code != FAULT_NONE);
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (any_fire && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    unique case (state_q)
      MON_INIT, MON_OK: begin
        if (any_fire) begin
          state_d = MON_FAULT;
          code_d  = fire_code;
        end else begin
          state_d = MON_OK;
        end
      end
      MON_FAULT: begin
        if (any_fire && clr_fault) begin
          code_d = fire_code;
        end else if (clr_fault) begin
          state_d = MON_INIT;
          code_d  = FAULT_NONE;
        end
      end
      default: begin
        state_d = MON_INIT;
        code_d  = FAULT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MON_INIT;
      code_q  <= FAULT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fault       = (state_q == MON_FAULT);
  assign force_flash = fault;
  assign fault_code  = code_q;
  assign fault_cnt   = cnt_q;

endmodule
